// File: rtl/asfifo_defs.sv
// asfifo_defs: shared definitions for the async-FIFO pointer logic.
//   ASFIFO_MODE_RD / ASFIFO_MODE_WR : side selector for asfifo_ptrgen.
//   bin2gray / gray2bin             : code conversion on a zero-extended
//                                     word; any pointer up to ASFIFO_MAXW
//                                     bits converts correctly because the
//                                     unused upper bits stay zero.
package asfifo_defs;

  localparam int ASFIFO_MODE_RD = 0;
  localparam int ASFIFO_MODE_WR = 1;

  localparam int unsigned ASFIFO_MAXW = 16;

  typedef logic [ASFIFO_MAXW-1:0] asfifo_word_t;

  function automatic asfifo_word_t bin2gray(input asfifo_word_t b);
    return b ^ (b >> 1);
  endfunction

  // XOR prefix from the MSB down.
  function automatic asfifo_word_t gray2bin(input asfifo_word_t g);
    asfifo_word_t b;
    b[ASFIFO_MAXW-1] = g[ASFIFO_MAXW-1];
    for (int unsigned i = 1; i < ASFIFO_MAXW; i++) begin
      b[ASFIFO_MAXW-1-i] = b[ASFIFO_MAXW-i] ^ g[ASFIFO_MAXW-1-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/asfifo_sync.sv
// asfifo_sync: multi-flop synchroniser for a Gray-coded bus.
//   clk, rst : destination clock, async active-high reset (clears all stages)
//   d_i      : unsynchronised input bus
//   q_o      : output of the last stage
module asfifo_sync #(
  parameter int unsigned width  = 5,
  parameter int unsigned stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [width-1:0] stage_q [stages];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < stages; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < stages; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[stages-1];

endmodule

// File: rtl/asfifo_ptrgen.sv
// asfifo_ptrgen: pointer and flag generator for one side of an async FIFO.
//   mode 0 = read side (flag = empty), mode 1 = write side (flag = full).
//   clk, rst    : side clock, async active-high reset
//   ce          : advance request; ignored while flag is set
//   gray_remote : opposite-domain Gray pointer (unsynchronised)
//   gray_ptr    : local Gray pointer for export
//   addr        : binary RAM address
//   flag        : empty / full
//   almost      : almost-empty / almost-full
//   level       : occupancy as seen from this side, 0..2^depth_log2
module asfifo_ptrgen
  import asfifo_defs::*;
#(
  parameter int unsigned depth_log2  = 4,
  parameter int          mode        = ASFIFO_MODE_RD,
  parameter int unsigned sync_stages = 2,
  parameter int unsigned threshold   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [depth_log2:0]   gray_remote,
  output logic [depth_log2:0]   gray_ptr,
  output logic [depth_log2-1:0] addr,
  output logic                  flag,
  output logic                  almost,
  output logic [depth_log2:0]   level
);

  localparam int unsigned W = depth_log2 + 1;
  localparam logic [W-1:0] ALMOST_EMPTY_AT = W'(threshold);
  localparam logic [W-1:0] ALMOST_FULL_AT  = W'((2 ** depth_log2) - threshold);
  localparam logic         FLAG_RST        = (mode == ASFIFO_MODE_RD);

  logic [W-1:0]            b_q, b_d;
  logic [W-1:0]            gray_q, g_d;
  logic [depth_log2-1:0]   addr_q;
  logic                    flag_q, flag_d;
  logic                    almost_q, almost_d;
  logic [W-1:0]            level_q, lvl_d;
  logic [W-1:0]            rs, rb, rs_full;
  logic                    adv;

  asfifo_sync #(
    .width  (W),
    .stages (sync_stages)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (gray_remote),
    .q_o (rs)
  );

  always_comb begin
    adv     = ce & ~flag_q;
    b_d     = b_q + W'(adv);
    g_d     = W'(bin2gray(asfifo_word_t'(b_d)));
    rb      = W'(gray2bin(asfifo_word_t'(rs)));
    // Full when the local pointer is exactly one lap ahead: top two Gray
    // bits inverted, the rest equal.
    rs_full = {~rs[W-1:W-2], rs[W-3:0]};
    if (mode == ASFIFO_MODE_RD) begin
      flag_d   = (g_d == rs);
      lvl_d    = rb - b_d;
      almost_d = (lvl_d <= ALMOST_EMPTY_AT);
    end else begin
      flag_d   = (g_d == rs_full);
      lvl_d    = b_d - rb;
      almost_d = (lvl_d >= ALMOST_FULL_AT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q      <= '0;
      gray_q   <= '0;
      addr_q   <= '0;
      level_q  <= '0;
      flag_q   <= FLAG_RST;
      almost_q <= FLAG_RST;
    end else begin
      b_q      <= b_d;
      gray_q   <= g_d;
      addr_q   <= b_d[depth_log2-1:0];
      level_q  <= lvl_d;
      flag_q   <= flag_d;
      almost_q <= almost_d;
    end
  end

  assign gray_ptr = gray_q;
  assign addr     = addr_q;
  assign flag     = flag_q;
  assign almost   = almost_q;
  assign level    = level_q;

endmodule

// File: tb/tb_asfifo_ptrgen.sv
module tb_asfifo_ptrgen;
  import asfifo_defs::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = N + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         ce_r, ce_w;
  logic [W-1:0] grem_r, grem_w;
  logic [W-1:0] gptr_r, gptr_w, level_r, level_w;
  logic [N-1:0] addr_r, addr_w;
  logic         flag_r, flag_w, almost_r, almost_w;

  int unsigned errs   = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  asfifo_ptrgen #(
    .depth_log2  (N),
    .mode        (ASFIFO_MODE_RD),
    .sync_stages (2),
    .threshold   (2)
  ) u_rd (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce_r),
    .gray_remote (grem_r),
    .gray_ptr    (gptr_r),
    .addr        (addr_r),
    .flag        (flag_r),
    .almost      (almost_r),
    .level       (level_r)
  );

  asfifo_ptrgen #(
    .depth_log2  (N),
    .mode        (ASFIFO_MODE_WR),
    .sync_stages (2),
    .threshold   (2)
  ) u_wr (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce_w),
    .gray_remote (grem_w),
    .gray_ptr    (gptr_w),
    .addr        (addr_w),
    .flag        (flag_w),
    .almost      (almost_w),
    .level       (level_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gray pointers may change at most one bit between consecutive edges.
  logic [W-1:0] prev_r, prev_w;
  bit           prev_ok = 1'b0;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok) begin
        check("gray_step_rd", 32'($countones(gptr_r ^ prev_r) <= 1), 1);
        check("gray_step_wr", 32'($countones(gptr_w ^ prev_w) <= 1), 1);
      end
      prev_r  = gptr_r;
      prev_w  = gptr_w;
      prev_ok = 1'b1;
    end
  end

  initial begin
    rst    = 1'b1;
    ce_r   = 1'b0;
    ce_w   = 1'b0;
    grem_r = '0;
    grem_w = '0;
    #1;
    // Reset values appear without any clock edge.
    check("rst_rd_flag",   flag_r,   1);
    check("rst_rd_almost", almost_r, 1);
    check("rst_rd_level",  level_r,  0);
    check("rst_rd_gray",   gptr_r,   0);
    check("rst_rd_addr",   addr_r,   0);
    check("rst_wr_flag",   flag_w,   0);
    check("rst_wr_almost", almost_w, 0);
    check("rst_wr_level",  level_w,  0);
    tick();
    rst = 1'b0;

    // Read strobes while empty are ignored.
    ce_r = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("empty_ce_addr", addr_r, 0);
      check("empty_ce_flag", flag_r, 1);
      check("empty_ce_lvl",  level_r, 0);
    end
    ce_r = 1'b0;

    // Reset mid-operation with b=0 and remote at bin 7.
    grem_r = 5'b00100;
    tick(); tick();
    check("t6_pre_lvl",  level_r, 0);
    check("t6_pre_flag", flag_r, 1);
    tick();
    check("t6_lvl",    level_r, 7);
    check("t6_flag",   flag_r, 0);
    check("t6_almost", almost_r, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_async_lvl",    level_r, 0);
    check("t6_async_flag",   flag_r, 1);
    check("t6_async_almost", almost_r, 1);
    check("t6_async_gray",   gptr_r, 0);
    check("t6_async_addr",   addr_r, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("t6_rel2_lvl",  level_r, 0);
    check("t6_rel2_flag", flag_r, 1);
    tick();
    check("t6_rel3_lvl",  level_r, 7);
    check("t6_rel3_flag", flag_r, 0);

    // Mode 0 drain from remote bin 5.
    rst = 1'b1;
    grem_r = 5'b00111;
    tick();
    rst = 1'b0;
    tick(); tick();
    check("t2_e2_flag", flag_r, 1);
    check("t2_e2_lvl",  level_r, 0);
    tick();
    check("t2_flag",   flag_r, 0);
    check("t2_lvl",    level_r, 5);
    check("t2_almost", almost_r, 0);
    ce_r = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t2_rd_lvl",    level_r, 32'(5 - k));
      check("t2_rd_addr",   addr_r, 32'(k));
      check("t2_rd_almost", almost_r, 32'((5 - k) <= 2));
      check("t2_rd_flag",   flag_r, 32'(k == 5));
    end
    check("t2_gray", gptr_r, 5'b00111);
    tick();
    check("t2_ign_addr", addr_r, 5);
    check("t2_ign_lvl",  level_r, 0);
    check("t2_ign_flag", flag_r, 1);
    ce_r = 1'b0;

    // Level 1, then a local read lands on the same edge the remote
    // write step first reaches the comparison: net delta zero.
    grem_r = 5'b00101;
    tick(); tick(); tick();
    check("t5_lvl1",    level_r, 1);
    check("t5_almost1", almost_r, 1);
    grem_r = 5'b00100;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t5_wait_lvl",  level_r, 1);
      check("t5_wait_flag", flag_r, 0);
    end
    ce_r = 1'b1;
    tick();
    ce_r = 1'b0;
    check("t5_net_lvl",  level_r, 1);
    check("t5_net_flag", flag_r, 0);
    check("t5_net_addr", addr_r, 6);
    tick(); tick();
    check("t5_hold_lvl",  level_r, 1);
    check("t5_hold_flag", flag_r, 0);

    // Mode 1 fill to full.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ce_w = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("t3_lvl",    level_w, 32'(k));
      check("t3_almost", almost_w, 32'(k >= 14));
      check("t3_flag",   flag_w, 32'(k == 16));
      check("t3_addr",   addr_w, 32'(k % 16));
    end
    check("t3_gray", gptr_w, 5'b11000);
    tick();
    check("t3_ign_lvl",  level_w, 16);
    check("t3_ign_addr", addr_w, 0);
    check("t3_ign_gray", gptr_w, 5'b11000);
    ce_w = 1'b0;

    // Mode 1 wrap of the binary counter.
    grem_w = 5'b11000;
    tick(); tick();
    check("t4_e2_flag", flag_w, 1);
    tick();
    check("t4_flag",   flag_w, 0);
    check("t4_lvl",    level_w, 0);
    check("t4_almost", almost_w, 0);
    ce_w = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("t4_wr_lvl",  level_w, 32'(k));
      check("t4_wr_flag", flag_w, 32'(k == 16));
    end
    ce_w = 1'b0;
    check("t4_gray",   gptr_w, 0);
    check("t4_addr",   addr_w, 0);
    check("t4_almost", almost_w, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
